// File: rtl/ysyx_25020037_gpr_sb.sv
// General-purpose register file with per-register scoreboard, writeback-to-read bypass
// and an issue-side valid/ready handshake for hazard-free back-to-back issue.
module ysyx_25020037_gpr_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned AW       = 5,
  parameter int unsigned MAX_PEND = 4,
  localparam int unsigned CW      = $clog2(MAX_PEND + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [AW-1:0]       iss_rs1,
  input  logic [AW-1:0]       iss_rs2,
  input  logic [AW-1:0]       iss_rd,
  input  logic                iss_rd_wen,
  output logic [XLEN-1:0]     iss_src1,
  output logic [XLEN-1:0]     iss_src2,
  input  logic                wb_valid,
  input  logic                wb_wen,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CW-1:0]       pend_cnt,
  output logic                illegal_reg
);

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [CW-1:0]       r_pend;
  logic                r_illegal;

  logic [NUM_REGS-1:0] w_busy_d;
  logic [CW-1:0]       w_pend_d;
  logic [XLEN-1:0]     w_rf1, w_rf2;
  logic                w_wb_fire, w_rd_ok, w_byp1, w_byp2, w_bypd;
  logic                w_haz1, w_haz2, w_hazd, w_clr, w_full;
  logic                w_iss_fire, w_set, w_ill;

  function automatic logic legal(input logic [AW-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  // Illegal indices never match a vector bit, so they read as not busy.
  function automatic logic busy_of(input logic [AW-1:0] idx, input logic [NUM_REGS-1:0] vec);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == AW'(i)) b = vec[i];
    end
    return b;
  endfunction

  assign w_wb_fire = wb_valid & wb_wen & legal(wb_rd) & (wb_rd != '0);
  assign w_rd_ok   = iss_rd_wen & legal(iss_rd) & (iss_rd != '0);
  assign w_byp1    = w_wb_fire & (wb_rd == iss_rs1);
  assign w_byp2    = w_wb_fire & (wb_rd == iss_rs2);
  assign w_bypd    = w_wb_fire & (wb_rd == iss_rd);

  assign w_haz1 = busy_of(iss_rs1, r_busy) & ~w_byp1;
  assign w_haz2 = busy_of(iss_rs2, r_busy) & ~w_byp2;
  assign w_hazd = iss_rd_wen & busy_of(iss_rd, r_busy) & ~w_bypd;
  assign w_clr  = w_wb_fire & busy_of(wb_rd, r_busy);
  // A clear in the same cycle frees a slot for the new destination.
  assign w_full = w_rd_ok & (r_pend == CW'(MAX_PEND)) & ~w_clr;

  assign iss_ready  = ~flush & ~w_haz1 & ~w_haz2 & ~w_hazd & ~w_full;
  assign w_iss_fire = iss_valid & iss_ready;
  assign w_set      = w_iss_fire & w_rd_ok;
  assign w_ill      = w_iss_fire & (~legal(iss_rs1) | ~legal(iss_rs2) |
                                    (iss_rd_wen & ~legal(iss_rd)));

  always_comb begin
    w_rf1 = '0;
    w_rf2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (iss_rs1 == AW'(i)) w_rf1 = r_regs[i];
      if (iss_rs2 == AW'(i)) w_rf2 = r_regs[i];
    end
  end

  assign iss_src1 = w_byp1 ? wb_data : w_rf1;
  assign iss_src2 = w_byp2 ? wb_data : w_rf2;

  // Set is applied after clear so a same-register set/clear keeps the bit.
  always_comb begin
    w_busy_d = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_clr && (wb_rd == AW'(i))) w_busy_d[i] = 1'b0;
      if (w_set && (iss_rd == AW'(i))) w_busy_d[i] = 1'b1;
    end
    w_pend_d = r_pend + CW'(w_set) - CW'(w_clr);
    if (flush) begin
      w_busy_d = '0;
      w_pend_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_fire) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wb_rd == AW'(i)) r_regs[i] <= wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy    <= '0;
      r_pend    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_busy    <= w_busy_d;
      r_pend    <= w_pend_d;
      r_illegal <= w_ill;
    end
  end

  assign busy_vec    = r_busy;
  assign pend_cnt    = r_pend;
  assign illegal_reg = r_illegal;

endmodule

// File: tb/tb_ysyx_25020037_gpr_sb.sv
// Directed bench for ysyx_25020037_gpr_sb: stimulus queues expected values, a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_ysyx_25020037_gpr_sb;

  localparam int XLEN = 32;
  localparam int NR   = 16;
  localparam int AW   = 5;
  localparam int MP   = 4;
  localparam int CW   = $clog2(MP + 1);

  localparam int F_READY = 0;
  localparam int F_SRC1  = 1;
  localparam int F_SRC2  = 2;
  localparam int F_BUSY  = 3;
  localparam int F_PEND  = 4;
  localparam int F_ILL   = 5;

  typedef struct {
    string       name;
    int          fld;
    logic [31:0] exp;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid, iss_rd_wen, wb_valid, wb_wen, flush;
  logic            iss_ready, illegal_reg;
  logic [AW-1:0]   iss_rs1, iss_rs2, iss_rd, wb_rd;
  logic [XLEN-1:0] iss_src1, iss_src2, wb_data;
  logic [NR-1:0]   busy_vec;
  logic [CW-1:0]   pend_cnt;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_25020037_gpr_sb #(.XLEN(XLEN), .NUM_REGS(NR), .AW(AW), .MAX_PEND(MP)) dut (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_rd     (iss_rd),
    .iss_rd_wen (iss_rd_wen),
    .iss_src1   (iss_src1),
    .iss_src2   (iss_src2),
    .wb_valid   (wb_valid),
    .wb_wen     (wb_wen),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .flush      (flush),
    .busy_vec   (busy_vec),
    .pend_cnt   (pend_cnt),
    .illegal_reg(illegal_reg)
  );

  task automatic exp_push(input string name, input int fld, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.fld  = fld;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    iss_valid = 0; iss_rd_wen = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    wb_valid = 0; wb_wen = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic issue(input int rs1, input int rs2, input int rd, input logic wen);
    iss_valid = 1; iss_rs1 = AW'(rs1); iss_rs2 = AW'(rs2); iss_rd = AW'(rd); iss_rd_wen = wen;
  endtask

  task automatic wb(input int rd, input logic [31:0] d);
    wb_valid = 1; wb_wen = 1; wb_rd = AW'(rd); wb_data = d;
  endtask

  // Monitor: compares every pending expectation against the settled outputs.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        case (e.fld)
          F_READY: act = 32'(iss_ready);
          F_SRC1:  act = iss_src1;
          F_SRC2:  act = iss_src2;
          F_BUSY:  act = 32'(busy_vec);
          F_PEND:  act = 32'(pend_cnt);
          default: act = 32'(illegal_reg);
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0;
    iss_valid = 0; iss_rd_wen = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    wb_valid = 0; wb_wen = 0; wb_rd = 0; wb_data = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;

    // Reset state and plain read
    cyc(); issue(3, 0, 0, 0);
    exp_push("rst_src1", F_SRC1, 0);   exp_push("rst_src2", F_SRC2, 0);
    exp_push("rst_ready", F_READY, 1); exp_push("rst_busy", F_BUSY, 0);
    exp_push("rst_pend", F_PEND, 0);   exp_push("rst_ill", F_ILL, 0);

    // RAW stall and bypass
    cyc(); issue(0, 0, 5, 1);
    exp_push("raw_issue_ready", F_READY, 1);
    cyc(); issue(5, 0, 0, 0);
    exp_push("raw_busy5", F_BUSY, 32'h20); exp_push("raw_pend1", F_PEND, 1);
    exp_push("raw_stall", F_READY, 0);
    cyc(); issue(5, 0, 0, 0); wb(5, 32'hDEADBEEF);
    exp_push("raw_byp_ready", F_READY, 1); exp_push("raw_byp_src1", F_SRC1, 32'hDEADBEEF);
    cyc(); iss_rs1 = 5;
    exp_push("raw_reg5", F_SRC1, 32'hDEADBEEF); exp_push("raw_busy_clr", F_BUSY, 0);
    exp_push("raw_pend0", F_PEND, 0);

    // WAW with same-cycle clear and set
    cyc(); issue(0, 0, 7, 1);
    exp_push("waw_first_ready", F_READY, 1);
    cyc(); issue(0, 0, 7, 1);
    exp_push("waw_stall", F_READY, 0); exp_push("waw_busy7", F_BUSY, 32'h80);
    cyc(); issue(0, 0, 7, 1); wb(7, 32'h77);
    exp_push("waw_clr_ready", F_READY, 1);
    cyc(); iss_rs1 = 7;
    exp_push("waw_set_wins", F_BUSY, 32'h80); exp_push("waw_pend_same", F_PEND, 1);
    exp_push("waw_reg7", F_SRC1, 32'h77);
    cyc(); wb(7, 32'h70);

    // Capacity limit
    cyc(); issue(0, 0, 1, 1);
    exp_push("cap_busy0", F_BUSY, 0); exp_push("cap_pend0", F_PEND, 0);
    cyc(); issue(0, 0, 2, 1); exp_push("cap_rd2", F_READY, 1);
    cyc(); issue(0, 0, 3, 1); exp_push("cap_rd3", F_READY, 1);
    cyc(); issue(0, 0, 4, 1); exp_push("cap_rd4", F_READY, 1);
    cyc(); issue(0, 0, 6, 1);
    exp_push("cap_pend4", F_PEND, 4); exp_push("cap_busy", F_BUSY, 32'h1E);
    exp_push("cap_full", F_READY, 0);
    cyc(); issue(0, 0, 6, 1); exp_push("cap_full2", F_READY, 0);
    cyc(); issue(0, 0, 6, 1); wb(1, 32'h11);
    exp_push("cap_clr_ready", F_READY, 1);
    cyc(); iss_rs1 = 9; wb(9, 32'h99);
    exp_push("cap_busy_swap", F_BUSY, 32'h5C); exp_push("cap_pend_swap", F_PEND, 4);
    exp_push("nonbusy_byp", F_SRC1, 32'h99);
    cyc(); wb(6, 32'h66);
    exp_push("no_underflow", F_PEND, 4);
    cyc();
    exp_push("pre_flush_busy", F_BUSY, 32'h1C); exp_push("pre_flush_pend", F_PEND, 3);

    // Flush with concurrent writeback
    cyc(); flush = 1; wb(2, 32'h55); issue(0, 0, 8, 1);
    exp_push("flush_ready", F_READY, 0);
    cyc(); iss_rs1 = 2;
    exp_push("flush_busy", F_BUSY, 0); exp_push("flush_pend", F_PEND, 0);
    exp_push("flush_wb_reg2", F_SRC1, 32'h55); exp_push("post_flush_ready", F_READY, 1);

    // Illegal indices
    cyc(); issue(20, 0, 17, 1);
    exp_push("ill_src1", F_SRC1, 0); exp_push("ill_ready", F_READY, 1);
    exp_push("ill_not_yet", F_ILL, 0);
    cyc();
    exp_push("ill_pulse", F_ILL, 1); exp_push("ill_no_busy", F_BUSY, 0);
    exp_push("ill_no_pend", F_PEND, 0);
    cyc(); wb(17, 32'hAAAA); iss_rs1 = 17; iss_rs2 = 1;
    exp_push("ill_one_cycle", F_ILL, 0); exp_push("ill_no_byp", F_SRC1, 0);
    exp_push("ill_reg1_byp", F_SRC2, 32'h11);
    cyc(); iss_rs1 = 1; iss_rs2 = 17;
    exp_push("ill_no_alias", F_SRC1, 32'h11); exp_push("ill_read0", F_SRC2, 0);

    // x0 never written or busy
    cyc(); wb(0, 32'hFFFF); issue(0, 0, 0, 1);
    exp_push("x0_no_byp", F_SRC1, 0); exp_push("x0_ready", F_READY, 1);
    cyc();
    exp_push("x0_read", F_SRC1, 0); exp_push("x0_no_busy", F_BUSY, 0);

    // Asynchronous reset mid-cycle
    cyc(); issue(0, 0, 3, 1);
    cyc(); iss_rs1 = 5;
    exp_push("pre_rst_busy", F_BUSY, 32'h08);
    @(negedge clk); #1;
    rst = 0; #1;
    exp_push("arst_busy", F_BUSY, 0); exp_push("arst_pend", F_PEND, 0);
    exp_push("arst_reg5", F_SRC1, 0);
    @(negedge clk); #1;
    rst = 1;

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
